uart_tx_fifo: RTL

Byte buffer between the UART receive path, or any byte producer, and the uart_tx transmitter. It absorbs single-cycle valid pulses into a circular FIFO. It then feeds uart_tx one byte at a time by pulsing uart_tx_en only when the transmitter is idle, and sequences on uart_tx_busy. Bursts that arrive while a frame is in flight are therefore not lost.

---
 rtl/uart_tx_fifo_if.sv | 47 ++++
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
//
// Purpose : Bundles the byte-producer side and the uart_tx side of the
//           uart_tx_fifo into one interface.
//
// Signals :
//   in_valid      producer -> fifo   single-cycle write strobe
//   in_data       producer -> fifo   word to enqueue
//   uart_tx_busy  tx       -> fifo   high while uart_tx shifts a frame
//   uart_tx_en    fifo     -> tx     one-cycle send request
//   uart_tx_data  fifo     -> tx     word being sent
//   fifo_count    fifo     -> env    number of stored words, 0..DEPTH
//   fifo_empty    fifo     -> env    fifo_count == 0
//   fifo_full     fifo     -> env    fifo_count == DEPTH
//   overflow      fifo     -> env    sticky, a write was dropped
//
// Modports:
//   master : the environment (byte producer plus transmitter)
//   slave  : the uart_tx_fifo itself
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DEPTH        = 16
);
    localparam int PTR_W = $clog2(DEPTH);

    logic                    in_valid;
    logic [PAYLOAD_BITS-1:0] in_data;
    logic                    uart_tx_busy;
    logic                    uart_tx_en;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic [PTR_W:0]          fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    overflow;

    modport master (
        output in_valid, in_data, uart_tx_busy,
        input  uart_tx_en, uart_tx_data, fifo_count, fifo_empty, fifo_full, overflow
    );

    modport slave (
        input  in_valid, in_data, uart_tx_busy,
        output uart_tx_en, uart_tx_data, fifo_count, fifo_empty, fifo_full, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Purpose : Circular byte FIFO in front of a uart_tx transmitter. Single-cycle
//           in_valid strobes are queued. Whenever the transmitter is idle,
//           one word is popped and handed over with a one-cycle uart_tx_en
//           pulse, and the FSM then follows uart_tx_busy through the frame.
//
// Ports   :
//   clk    input  system clock, rising edge
//   reset  input  synchronous active-high reset, priority over everything
//   bus    uart_tx_fifo_if.slave
//            in_valid/in_data            write side
//            uart_tx_busy                transmitter status
//            uart_tx_en/uart_tx_data     transmitter request
//            fifo_count/empty/full       occupancy
//            overflow                    sticky dropped-write flag
//
// DEPTH must be a power of two and at least 2. The pointers then wrap by
// plain PTR_W-bit rollover, and a separate count tells full from empty.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter  int PAYLOAD_BITS = 8,
    parameter  int DEPTH        = 16,
    localparam int PTR_W        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_e;

    state_e                  state_q;
    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    tx_en_q;
    logic [PAYLOAD_BITS-1:0] tx_data_q;
    logic [1:0]              wait_cnt_q;

    logic pop;
    logic push;
    logic drop;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here by computing it unconditionally first); otherwise a latch is inferred.
    always_comb begin
        // A pop needs a stored word and an idle transmitter, and only ever
        // happens on the IDLE->LOAD transition.
        pop  = (state_q == S_IDLE) && (count_q != '0) && !bus.uart_tx_busy;
        // A full FIFO still accepts a write if a pop frees a slot the same cycle.
        push = bus.in_valid && ((count_q != FULL_COUNT) || pop);
        drop = bus.in_valid && !push;

        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q | drop;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: the storage array has no reset. Its contents are only read
    // behind a non-zero count, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments, so every register
    // samples pre-edge values and the order of statements does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        // The word stays on uart_tx_data until the next pop.
                        tx_data_q <= mem_q[rd_ptr_q];
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_en_q <= 1'b1;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    tx_en_q    <= 1'b0;
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // Give up after four cycles without busy, so a lost start
                    // cannot stall the queue forever.
                    if (bus.uart_tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (wait_cnt_q == 2'd3) begin
                        state_q <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.uart_tx_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tx_en_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.uart_tx_en   = tx_en_q;
    assign bus.uart_tx_data = tx_data_q;
    assign bus.fifo_count   = count_q;
    assign bus.fifo_empty   = (count_q == '0);
    assign bus.fifo_full    = (count_q == FULL_COUNT);
    assign bus.overflow     = overflow_q;
endmodule
